// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram-like request arbiter: source ids, size
// encodings and bus field widths.
package sram_req_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int SIZE_W  = 2;
    localparam int WSTRB_W = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    function automatic logic size_legal(input logic [SIZE_W-1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
    endfunction

endpackage

// File: rtl/sram_arb_order_fifo.sv
// 1-bit-wide sync FIFO remembering which master issued each accepted request,
// so responses can be routed back in issue order.
module sram_arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= din;
                tail      <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between the instruction and data masters, holding
// the grant until addr_ok and routing in-order responses back to their issuer.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_sram_req,
    input  logic               inst_sram_wr,
    input  logic [SIZE_W-1:0]  inst_sram_size,
    input  logic [WSTRB_W-1:0] inst_sram_wstrb,
    input  logic [ADDR_W-1:0]  inst_sram_addr,
    input  logic [DATA_W-1:0]  inst_sram_wdata,
    output logic               inst_sram_addr_ok,
    output logic               inst_sram_data_ok,
    output logic [DATA_W-1:0]  inst_sram_rdata,
    input  logic               data_sram_req,
    input  logic               data_sram_wr,
    input  logic [SIZE_W-1:0]  data_sram_size,
    input  logic [WSTRB_W-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0]  data_sram_addr,
    input  logic [DATA_W-1:0]  data_sram_wdata,
    output logic               data_sram_addr_ok,
    output logic               data_sram_data_ok,
    output logic [DATA_W-1:0]  data_sram_rdata,
    output logic               mem_sram_req,
    output logic               mem_sram_wr,
    output logic [SIZE_W-1:0]  mem_sram_size,
    output logic [WSTRB_W-1:0] mem_sram_wstrb,
    output logic [ADDR_W-1:0]  mem_sram_addr,
    output logic [DATA_W-1:0]  mem_sram_wdata,
    input  logic               mem_sram_addr_ok,
    input  logic               mem_sram_data_ok,
    input  logic [DATA_W-1:0]  mem_sram_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic            lock_q;
    src_e            lock_src_q;
    logic [SC_W-1:0] starve_cnt;
    logic            grant_valid;
    src_e            grant_src;
    logic            handshake;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_head;
    logic            resp_pop;
    logic            inst_starved;

    assign inst_starved = (starve_cnt == SC_W'(STARVE_LIMIT));

    // A full FIFO blocks every grant; a locked grant stays with its owner.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_DATA;
        if (!fifo_full) begin
            if (lock_q) begin
                grant_src   = lock_src_q;
                grant_valid = (lock_src_q == SRC_INST) ? inst_sram_req : data_sram_req;
            end else if (inst_sram_req && (inst_starved || !data_sram_req)) begin
                grant_src   = SRC_INST;
                grant_valid = 1'b1;
            end else if (data_sram_req) begin
                grant_src   = SRC_DATA;
                grant_valid = 1'b1;
            end
        end
    end

    assign handshake      = grant_valid && mem_sram_addr_ok;
    assign mem_sram_req   = grant_valid;
    assign mem_sram_wr    = (grant_src == SRC_INST) ? inst_sram_wr    : data_sram_wr;
    assign mem_sram_size  = (grant_src == SRC_INST) ? inst_sram_size  : data_sram_size;
    assign mem_sram_wstrb = (grant_src == SRC_INST) ? inst_sram_wstrb : data_sram_wstrb;
    assign mem_sram_addr  = (grant_src == SRC_INST) ? inst_sram_addr  : data_sram_addr;
    assign mem_sram_wdata = (grant_src == SRC_INST) ? inst_sram_wdata : data_sram_wdata;

    assign inst_sram_addr_ok = handshake && (grant_src == SRC_INST);
    assign data_sram_addr_ok = handshake && (grant_src == SRC_DATA);

    assign resp_pop          = mem_sram_data_ok && !fifo_empty;
    assign inst_sram_data_ok = resp_pop && (fifo_head == SRC_INST);
    assign data_sram_data_ok = resp_pop && (fifo_head == SRC_DATA);
    assign inst_sram_rdata   = mem_sram_rdata;
    assign data_sram_rdata   = mem_sram_rdata;

    sram_arb_order_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (handshake),
        .pop   (resp_pop),
        .din   (grant_src),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INST;
        end else if (handshake) begin
            lock_q <= 1'b0;
        end else if (grant_valid) begin
            lock_q     <= 1'b1;
            lock_src_q <= grant_src;
        end
    end

    // Counts data wins while inst is waiting; inst wins once it saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst_sram_req || inst_sram_addr_ok) begin
            starve_cnt <= '0;
        end else if (data_sram_addr_ok && !inst_starved) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        mem_sram_data_ok |-> !fifo_empty);

    assert property (@(posedge clk) disable iff (reset)
        lock_q |-> ((lock_src_q == SRC_INST) ? inst_sram_req : data_sram_req));

    assert property (@(posedge clk) disable iff (reset)
        inst_sram_req |-> size_legal(inst_sram_size));

    assert property (@(posedge clk) disable iff (reset)
        data_sram_req |-> size_legal(data_sram_size));

endmodule
